capture_ctrl: RTL and testbench
===============================

Name: capture_ctrl

Overview:
- Sequences one logic-analyzer capture on the LVDS byte stream: arm, wait for trigger, forward N words of bytes into the 8-to-32 packer, then drain.
- Sits between the LVDS deserializer output and the packer input.
- Counts the packed words the packer emits toward the FIFO.
- Flags FIFO overflow and keeps the packer word-aligned on abort.

Parameters:
- LVDS_LEN, 8, sample byte width; the packer packs 4 such bytes per word.
- CNT_W, 24, width of the word-count request and counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  pulse; arms a capture from IDLE or DONE.
- abort_i  in  1  pulse; ends the capture early.
- num_words_i  in  CNT_W  words to capture; latched on start.
- trig_mask_i  in  LVDS_LEN  trigger mask; latched on start.
- trig_val_i  in  LVDS_LEN  trigger value; latched on start.
- sample_valid_i  in  1  sample strobe from the deserializer.
- sample_i  in  LVDS_LEN  sample byte.
- pack_valid_o  out  1  byte strobe to the packer.
- pack_data_o  out  LVDS_LEN  byte to the packer.
- pack_word_valid_i  in  1  packer word strobe (the FIFO write).
- fifo_full_i  in  1  FIFO full flag.
- busy_o  out  1  high in ARMED, CAPTURE, PAD, DRAIN.
- done_o  out  1  high in DONE.
- overflow_o  out  1  sticky; a word was written while the FIFO was full.
- aborted_o  out  1  sticky; the capture ended via abort.
- state_o  out  3  current state encoding.
- words_cnt_o  out  CNT_W  packer words seen in this capture.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0; latched registers and counters 0.
- State encoding: IDLE=0, ARMED=1, CAPTURE=2, PAD=3, DRAIN=4, DONE=5.
- IDLE/DONE + start_i:
  - Latch num_words_i, trig_mask_i, trig_val_i.
  - Clear words_cnt, byte count, overflow_o, aborted_o.
  - Next state ARMED, or DONE directly if num_words_i==0.
- ARMED: trigger when sample_valid_i && ((sample_i ^ trig_val) & trig_mask)==0.
  - mask==0 triggers on the first valid sample.
  - The trigger byte is the first captured byte; next state CAPTURE.
- CAPTURE: every sample_valid_i forwards its byte.
- Byte forwarding (ARMED trigger and CAPTURE):
  - Registered, 1-cycle latency: pack_valid_o/pack_data_o at t+1 for a sample at t.
  - pack_valid_o is 0 in all other cycles except PAD.
- Byte counting: byte counter width CNT_W+2, target num_words*4.
  - The cycle the target-th byte is forwarded, the next state is DRAIN.
- PAD: entered on abort_i while in CAPTURE.
  - Forward 0x00 bytes, one per cycle, until the 2 LSBs of the forwarded-byte count are 0, so the packer ends word-aligned.
  - If the count is already aligned, emit no pad bytes.
  - Then DRAIN; aborted_o=1.
- Abort in ARMED: go to DONE with aborted_o=1; no bytes forwarded.
- abort_i in IDLE, DONE, PAD or DRAIN: ignored.
- start_i outside IDLE/DONE: ignored.
- DRAIN: wait until words_cnt equals the expected word count.
  - Expected count is num_words, or forwarded_bytes/4 after abort.
  - DONE is entered the cycle after the final pack_word_valid_i.
- words_cnt_o increments on pack_word_valid_i in CAPTURE, PAD and DRAIN. It saturates at all-ones.
- Overflow: pack_word_valid_i && fifo_full_i sets overflow_o (sticky). The capture continues; the FIFO drops the word.
- Simultaneous abort_i and final byte: final byte wins; go to DRAIN, aborted_o=0.
- Simultaneous start_i and abort_i in DONE: start wins.
- rst mid-capture: immediate return to IDLE.
  - The packer shares the same reset, so its byte phase is also cleared.
- DONE holds until start_i; done_o is a level, not a pulse.

Decomposition:
- Shared package holds:
  - State encoding constants.
  - BYTES_PER_WORD=4 (derived as DATA_LEN/LVDS_LEN).
  - CNT_W default.
- One sub-module is natural: capture_trigger.
  - Registers mask/value.
  - Produces a single-cycle match pulse gated by sample_valid_i in ARMED.
- FSM and counters stay in capture_ctrl.

Test Plan:
- mask=0x00, num_words=2, 8 consecutive valid bytes 0x01..0x08 -> pack_valid_o 8 cycles, 1 cycle behind input. With the packer attached: 2 words 0x04030201, 0x08070605; done_o=1; words_cnt_o=2.
- mask=0xFF, val=0xA5, stream 0x11,0x22,0xA5,0x33.. with num_words=1 -> first forwarded byte 0xA5; word 0x<b4><b3><b2>A5; bytes before the trigger are never forwarded.
- num_words=4, abort_i after 6 bytes forwarded -> state PAD, two 0x00 bytes emitted, 2 words total, aborted_o=1, DONE.
- fifo_full_i=1 during the 2nd pack_word_valid_i -> overflow_o=1 sticky through DONE; cleared by the next start_i.
- start_i with num_words_i=0 -> DONE the next cycle; pack_valid_o never asserted; busy_o stays 0.
- rst=1 pulse in CAPTURE after 3 bytes -> IDLE, all outputs 0. A new capture of 1 word yields the correct aligned word.

Source files
------------

// File: rtl/capture_ctrl_pkg.sv
// Shared constants and state encoding for the logic-analyzer capture sequencer.
package capture_ctrl_pkg;

    localparam int unsigned LVDS_LEN_DEF   = 8;
    localparam int unsigned DATA_LEN       = 32;
    localparam int unsigned BYTES_PER_WORD = DATA_LEN / LVDS_LEN_DEF;
    localparam int unsigned BW_LSB         = $clog2(BYTES_PER_WORD);
    localparam int unsigned CNT_W_DEF      = 24;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_PAD     = 3'd3,
        ST_DRAIN   = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

endpackage

// File: rtl/capture_ctrl_trigger.sv
// Holds the trigger mask/value for one capture and flags the first matching sample.
module capture_trigger
    import capture_ctrl_pkg::*;
#(
    parameter int unsigned LVDS_LEN = LVDS_LEN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_i,
    input  logic [LVDS_LEN-1:0] trig_mask_i,
    input  logic [LVDS_LEN-1:0] trig_val_i,
    input  logic                armed_i,
    input  logic                sample_valid_i,
    input  logic [LVDS_LEN-1:0] sample_i,
    output logic                match_o
);

    logic [LVDS_LEN-1:0] mask_q;
    logic [LVDS_LEN-1:0] val_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q <= '0;
            val_q  <= '0;
        end else if (load_i) begin
            mask_q <= trig_mask_i;
            val_q  <= trig_val_i;
        end
    end

    // Only asserted while armed; the FSM leaves ARMED on the hit, so it is a single pulse.
    assign match_o = armed_i && sample_valid_i && (((sample_i ^ val_q) & mask_q) == '0);

endmodule

// File: rtl/capture_ctrl.sv
// Capture sequencer: arm, trigger, forward bytes to the 8-to-32 packer, pad on abort, drain.
module capture_ctrl
    import capture_ctrl_pkg::*;
#(
    parameter int unsigned LVDS_LEN = LVDS_LEN_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic [CNT_W-1:0]    num_words_i,
    input  logic [LVDS_LEN-1:0] trig_mask_i,
    input  logic [LVDS_LEN-1:0] trig_val_i,
    input  logic                sample_valid_i,
    input  logic [LVDS_LEN-1:0] sample_i,
    output logic                pack_valid_o,
    output logic [LVDS_LEN-1:0] pack_data_o,
    input  logic                pack_word_valid_i,
    input  logic                fifo_full_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                overflow_o,
    output logic                aborted_o,
    output logic [2:0]          state_o,
    output logic [CNT_W-1:0]    words_cnt_o
);

    localparam int unsigned BC_W = CNT_W + BW_LSB;

    state_e              state_q;
    logic [CNT_W-1:0]    num_words_q;
    logic [CNT_W-1:0]    words_cnt_q, words_cnt_d;
    logic [BC_W-1:0]     byte_cnt_q, byte_cnt_inc, byte_target;
    logic                overflow_q, overflow_d;
    logic                aborted_q;
    logic                pack_valid_q;
    logic [LVDS_LEN-1:0] pack_data_q;
    logic                word_active, start_ok, trig_hit;

    assign start_ok = ((state_q == ST_IDLE) || (state_q == ST_DONE)) && start_i;

    capture_trigger #(.LVDS_LEN(LVDS_LEN)) u_trigger (
        .clk            (clk),
        .rst            (rst),
        .load_i         (start_ok),
        .trig_mask_i    (trig_mask_i),
        .trig_val_i     (trig_val_i),
        .armed_i        (state_q == ST_ARMED),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .match_o        (trig_hit)
    );

    always_comb begin
        word_active  = (state_q == ST_CAPTURE) || (state_q == ST_PAD) || (state_q == ST_DRAIN);
        byte_cnt_inc = byte_cnt_q + BC_W'(1);
        byte_target  = {num_words_q, {BW_LSB{1'b0}}};
        words_cnt_d  = words_cnt_q;
        if (word_active && pack_word_valid_i && (words_cnt_q != '1))
            words_cnt_d = words_cnt_q + CNT_W'(1);
        overflow_d   = overflow_q | (word_active & pack_word_valid_i & fifo_full_i);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            num_words_q  <= '0;
            words_cnt_q  <= '0;
            byte_cnt_q   <= '0;
            overflow_q   <= 1'b0;
            aborted_q    <= 1'b0;
            pack_valid_q <= 1'b0;
            pack_data_q  <= '0;
        end else begin
            pack_valid_q <= 1'b0;
            words_cnt_q  <= words_cnt_d;
            overflow_q   <= overflow_d;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        num_words_q <= num_words_i;
                        words_cnt_q <= '0;
                        byte_cnt_q  <= '0;
                        overflow_q  <= 1'b0;
                        aborted_q   <= 1'b0;
                        state_q     <= (num_words_i == '0) ? ST_DONE : ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (abort_i) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else if (trig_hit) begin
                        pack_valid_q <= 1'b1;
                        pack_data_q  <= sample_i;
                        byte_cnt_q   <= byte_cnt_inc;
                        state_q      <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (sample_valid_i) begin
                        pack_valid_q <= 1'b1;
                        pack_data_q  <= sample_i;
                        byte_cnt_q   <= byte_cnt_inc;
                    end
                    // The final byte takes priority over a coincident abort.
                    if (sample_valid_i && (byte_cnt_inc == byte_target)) begin
                        state_q <= ST_DRAIN;
                    end else if (abort_i) begin
                        aborted_q <= 1'b1;
                        state_q   <= ST_PAD;
                    end
                end
                ST_PAD: begin
                    if (byte_cnt_q[BW_LSB-1:0] != '0) begin
                        pack_valid_q <= 1'b1;
                        pack_data_q  <= '0;
                        byte_cnt_q   <= byte_cnt_inc;
                        if (byte_cnt_inc[BW_LSB-1:0] == '0)
                            state_q <= ST_DRAIN;
                    end else begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Byte count is word-aligned here, so it gives the expected word count in both exits.
                    if (words_cnt_q == byte_cnt_q[BC_W-1:BW_LSB])
                        state_q <= ST_DONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign pack_valid_o = pack_valid_q;
    assign pack_data_o  = pack_data_q;
    assign busy_o       = (state_q == ST_ARMED) || word_active;
    assign done_o       = (state_q == ST_DONE);
    assign overflow_o   = overflow_q;
    assign aborted_o    = aborted_q;
    assign state_o      = state_q;
    assign words_cnt_o  = words_cnt_q;

endmodule

// File: tb/tb_capture_ctrl.sv
// Directed bench for capture_ctrl with a behavioural 8-to-32 packer and byte/word scoreboards.
module tb_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [23:0] num_words_i;
    logic [7:0]  trig_mask_i, trig_val_i;
    logic        sample_valid_i;
    logic [7:0]  sample_i;
    logic        pack_valid_o;
    logic [7:0]  pack_data_o;
    logic        pack_word_valid_i;
    logic        fifo_full_i;
    logic        busy_o, done_o, overflow_o, aborted_o;
    logic [2:0]  state_o;
    logic [23:0] words_cnt_o;

    capture_ctrl #(.LVDS_LEN(8), .CNT_W(24)) dut (
        .clk               (clk),
        .rst               (rst),
        .start_i           (start_i),
        .abort_i           (abort_i),
        .num_words_i       (num_words_i),
        .trig_mask_i       (trig_mask_i),
        .trig_val_i        (trig_val_i),
        .sample_valid_i    (sample_valid_i),
        .sample_i          (sample_i),
        .pack_valid_o      (pack_valid_o),
        .pack_data_o       (pack_data_o),
        .pack_word_valid_i (pack_word_valid_i),
        .fifo_full_i       (fifo_full_i),
        .busy_o            (busy_o),
        .done_o            (done_o),
        .overflow_o        (overflow_o),
        .aborted_o         (aborted_o),
        .state_o           (state_o),
        .words_cnt_o       (words_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         c;
    } be_t;

    be_t         exp_b[$];
    logic [31:0] exp_w[$];
    int          vecs = 0;
    int          fails = 0;
    int          cyc = 0;
    int          word_seq = 0;
    int          full_when = 0;
    int          ph = 0;
    logic [31:0] acc = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // Packer model and scoreboard: bytes seen on the falling edge, word strobe presented for the next rising edge.
    always @(negedge clk) begin
        be_t e;
        pack_word_valid_i = 1'b0;
        fifo_full_i       = 1'b0;
        if (pack_valid_o) begin
            if (exp_b.size() == 0) begin
                chk("byte_spurious", {31'd0, pack_valid_o}, 32'd0);
            end else begin
                e = exp_b.pop_front();
                chk("byte_data", {24'd0, pack_data_o}, {24'd0, e.d});
                chk("byte_cycle", cyc, e.c);
            end
            acc = {pack_data_o, acc[31:8]};
            ph++;
            if (ph == 4) begin
                ph = 0;
                word_seq++;
                pack_word_valid_i = 1'b1;
                fifo_full_i       = (word_seq == full_when);
                if (exp_w.size() == 0) chk("word_spurious", acc, 32'hxxxx_xxxx);
                else chk("word_data", acc, exp_w.pop_front());
            end
        end
        if (rst) ph = 0;
    end

    task automatic start(input logic [23:0] n, input logic [7:0] m, input logic [7:0] v);
        start_i = 1'b1; num_words_i = n; trig_mask_i = m; trig_val_i = v;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit fwd);
        be_t e;
        sample_valid_i = 1'b1; sample_i = b;
        if (fwd) begin
            e.d = b; e.c = cyc + 1;
            exp_b.push_back(e);
        end
        @(posedge clk); #1;
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done_o && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk(tag, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        be_t e;
        rst = 1'b1; start_i = 0; abort_i = 0; num_words_i = '0;
        trig_mask_i = '0; trig_val_i = '0; sample_valid_i = 0; sample_i = '0;
        pack_word_valid_i = 0; fifo_full_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", {29'd0, state_o}, 32'd0);
        chk("rst_busy", {31'd0, busy_o}, 32'd0);
        chk("rst_done", {31'd0, done_o}, 32'd0);
        chk("rst_pvalid", {31'd0, pack_valid_o}, 32'd0);
        chk("rst_words", {8'd0, words_cnt_o}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Mask 0: trigger on first byte, 2 words
        exp_w.push_back(32'h04030201); exp_w.push_back(32'h08070605);
        start(24'd2, 8'h00, 8'h00);
        chk("t1_armed", {29'd0, state_o}, 32'd1);
        chk("t1_busy", {31'd0, busy_o}, 32'd1);
        for (int i = 1; i <= 8; i++) send(8'(i), 1'b1);
        chk("t1_drain", {29'd0, state_o}, 32'd4);
        wait_done("t1_done");
        chk("t1_words", {8'd0, words_cnt_o}, 32'd2);
        chk("t1_aborted", {31'd0, aborted_o}, 32'd0);
        chk("t1_overflow", {31'd0, overflow_o}, 32'd0);

        // Exact trigger match on 0xA5, earlier bytes dropped, extra byte after the word dropped
        exp_w.push_back(32'h554433A5);
        start(24'd1, 8'hFF, 8'hA5);
        send(8'h11, 1'b0); send(8'h22, 1'b0);
        chk("t2_still_armed", {29'd0, state_o}, 32'd1);
        send(8'hA5, 1'b1);
        chk("t2_capture", {29'd0, state_o}, 32'd2);
        send(8'h33, 1'b1); send(8'h44, 1'b1); send(8'h55, 1'b1); send(8'h66, 1'b0);
        wait_done("t2_done");
        chk("t2_words", {8'd0, words_cnt_o}, 32'd1);

        // Abort after 6 bytes: two zero pad bytes keep the packer aligned
        exp_w.push_back(32'h04030201); exp_w.push_back(32'h00000605);
        start(24'd4, 8'h00, 8'h00);
        for (int i = 1; i <= 6; i++) send(8'(i), 1'b1);
        abort_i = 1'b1;
        e.d = 8'h00; e.c = cyc + 2; exp_b.push_back(e);
        e.d = 8'h00; e.c = cyc + 3; exp_b.push_back(e);
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("t3_pad", {29'd0, state_o}, 32'd3);
        wait_done("t3_done");
        chk("t3_aborted", {31'd0, aborted_o}, 32'd1);
        chk("t3_words", {8'd0, words_cnt_o}, 32'd2);

        // FIFO full on the second word of the capture
        exp_w.push_back(32'h24232221); exp_w.push_back(32'h28272625);
        full_when = word_seq + 2;
        start(24'd2, 8'h00, 8'h00);
        for (int i = 1; i <= 8; i++) send(8'(8'h20 + i), 1'b1);
        wait_done("t4_done");
        chk("t4_overflow", {31'd0, overflow_o}, 32'd1);
        chk("t4_words", {8'd0, words_cnt_o}, 32'd2);

        // Zero-length capture from DONE also clears overflow
        start(24'd0, 8'h00, 8'h00);
        chk("t5_state", {29'd0, state_o}, 32'd5);
        chk("t5_busy", {31'd0, busy_o}, 32'd0);
        chk("t5_overflow", {31'd0, overflow_o}, 32'd0);
        chk("t5_words", {8'd0, words_cnt_o}, 32'd0);

        // Abort while armed, then start+abort together in DONE
        start(24'd3, 8'hFF, 8'h00);
        abort_i = 1'b1;
        @(posedge clk); #1;
        abort_i = 1'b0;
        chk("ta_state", {29'd0, state_o}, 32'd5);
        chk("ta_aborted", {31'd0, aborted_o}, 32'd1);
        exp_w.push_back(32'h13121110);
        abort_i = 1'b1;
        start(24'd1, 8'h00, 8'h00);
        abort_i = 1'b0;
        chk("tb_state", {29'd0, state_o}, 32'd1);
        chk("tb_aborted", {31'd0, aborted_o}, 32'd0);
        for (int i = 0; i < 4; i++) send(8'(8'h10 + i), 1'b1);
        wait_done("tb_done");

        // Reset mid-capture, then a clean 1-word capture
        start(24'd2, 8'h00, 8'h00);
        for (int i = 1; i <= 3; i++) send(8'(i), 1'b1);
        chk("t6_capture", {29'd0, state_o}, 32'd2);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_state", {29'd0, state_o}, 32'd0);
        chk("t6_pvalid", {31'd0, pack_valid_o}, 32'd0);
        chk("t6_busy", {31'd0, busy_o}, 32'd0);
        chk("t6_words", {8'd0, words_cnt_o}, 32'd0);
        exp_w.push_back(32'hEFBEADDE);
        start(24'd1, 8'h00, 8'h00);
        send(8'hDE, 1'b1); send(8'hAD, 1'b1); send(8'hBE, 1'b1); send(8'hEF, 1'b1);
        wait_done("t6_done");
        chk("t6_words_end", {8'd0, words_cnt_o}, 32'd1);

        repeat (3) @(posedge clk);
        #1;
        chk("bytes_left", exp_b.size(), 32'd0);
        chk("words_left", exp_w.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
